// File: rtl/uart_rx_ovs.sv
// uart_rx_ovs: oversampling UART receiver, 8 data bits, LSB first, idle-high.
// Each bit is the majority vote of three samples around the bit centre.
// Define UART_RX_PARITY_EN to accept frames with a parity bit between the
// data and the stop bit.
// CLKS_PER_BIT must be even and >= 8.
module uart_rx_ovs #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit ODD_PARITY   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_data_fresh,
   output logic       framing_err,
   output logic       glitch_err,
   output logic       parity_err,
   output logic       rx_busy
);

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int PW = $clog2(CLKS_PER_BIT);

   localparam logic [PW-1:0] PH_S0   = PW'(H - 1);
   localparam logic [PW-1:0] PH_S1   = PW'(H);
   localparam logic [PW-1:0] PH_DEC  = PW'(H + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BRK    = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd4,
      BRK    = 3'd5
   } state_t;
`endif

   state_t          state;
   logic            sync1;
   logic            rxd_s;
   logic [PW-1:0]   phase;
   logic [2:0]      bit_cnt;
   logic            s0;
   logic            s1;
   logic [7:0]      shift;
   logic            decide;
   logic            maj;

   // Majority of the two stored samples and the live one, valid at the decision phase.
   always_comb begin
      decide = (phase == PH_DEC);
      maj    = (s0 & s1) | (s0 & rxd_s) | (s1 & rxd_s);
   end

   // Two-flop synchroniser for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxd_s <= sync1;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit;
`endif

   // Receive FSM: phase counting, sampling, bit assembly and strobe generation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         phase         <= '0;
         bit_cnt       <= '0;
         s0            <= 1'b1;
         s1            <= 1'b1;
         shift         <= '0;
         rx_data       <= 8'h00;
         rx_data_fresh <= 1'b0;
         framing_err   <= 1'b0;
         glitch_err    <= 1'b0;
         rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit       <= 1'b0;
         parity_err    <= 1'b0;
`endif
      end else begin
         rx_data_fresh <= 1'b0;
         framing_err   <= 1'b0;
         glitch_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err    <= 1'b0;
`endif
         // Phase is pinned to 0 while idle so the start edge defines phase 0.
         if (state == IDLE || phase == PH_LAST) begin
            phase <= '0;
         end else begin
            phase <= phase + 1'b1;
         end
         if (phase == PH_S0) begin
            s0 <= rxd_s;
         end
         if (phase == PH_S1) begin
            s1 <= rxd_s;
         end

         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state   <= START;
                  rx_busy <= 1'b1;
               end
            end
            START: begin
               if (decide) begin
                  if (maj) begin
                     glitch_err <= 1'b1;
                     state      <= IDLE;
                     rx_busy    <= 1'b0;
                  end else begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
            end
            DATA: begin
               if (decide) begin
                  shift   <= {maj, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (decide) begin
                  par_bit <= maj;
                  state   <= STOP;
               end
            end
`endif
            STOP: begin
               if (decide) begin
                  if (maj) begin
                     // Leave at the stop-bit centre so a following start edge is not missed.
                     rx_data       <= shift;
                     rx_data_fresh <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err    <= par_bit ^ (^shift) ^ ODD_PARITY;
`endif
                     state         <= IDLE;
                     rx_busy       <= 1'b0;
                  end else begin
                     framing_err <= 1'b1;
                     state       <= BRK;
                  end
               end
            end
            BRK: begin
               // Line held low: wait for idle without raising further strobes.
               if (rxd_s) begin
                  state   <= IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   // No parity bit in the frame, so the strobe stays low; ODD_PARITY has no effect here.
   assign parity_err = ODD_PARITY & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs at CLKS_PER_BIT=16, even parity when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx_ovs;

   localparam int CPB    = 16;
   localparam int H      = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_EN = 1;
`else
   localparam int PAR_EN = 0;
`endif
   // Start edge to fresh strobe, including the stop-bit sampling.
   localparam int LAT    = (9 + PAR_EN) * CPB + H + 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_data_fresh;
   logic       framing_err;
   logic       glitch_err;
   logic       parity_err;
   logic       rx_busy;

   always #5 clk = ~clk;

   uart_rx_ovs #(.CLKS_PER_BIT(CPB), .ODD_PARITY(1'b0)) dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .rx_data       (rx_data),
      .rx_data_fresh (rx_data_fresh),
      .framing_err   (framing_err),
      .glitch_err    (glitch_err),
      .parity_err    (parity_err),
      .rx_busy       (rx_busy)
   );

   int pcnt = 0;
   always @(posedge clk) pcnt++;

   // Strobe monitor, sampled on the falling edge.
   int         n_fresh   = 0;
   int         n_ferr    = 0;
   int         n_gerr    = 0;
   int         n_perr    = 0;
   int         n_excl    = 0;
   int         fresh_cyc = 0;
   logic [7:0] fresh_q[$];

   always @(negedge clk) begin
      if (rx_data_fresh === 1'b1) begin
         n_fresh++;
         fresh_cyc = pcnt;
         fresh_q.push_back(rx_data);
      end
      if (framing_err === 1'b1) n_ferr++;
      if (glitch_err === 1'b1) n_gerr++;
      if (parity_err === 1'b1) n_perr++;
      if (int'(rx_data_fresh) + int'(framing_err) + int'(glitch_err) > 1) n_excl++;
      if (parity_err === 1'b1 && rx_data_fresh !== 1'b1) n_excl++;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic flip,
                             output int start_cyc);
      start_cyc = pcnt;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (PAR_EN == 1) send_bit((^d) ^ flip);
      send_bit(stop_b);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop_b;
      logic       flip;
      int         exp_fresh;
      logic [7:0] exp_data;
      int         exp_ferr;
      int         exp_perr;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

   // Global time limit.
   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int sc;
      int f0, fe0, g0, p0, qb, lat, w, got;

      vecs[0] = '{8'h61, 1'b1, 1'b0, 1, 8'h61, 0, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0, 0};
      vecs[3] = '{8'h80, 1'b1, 1'b0, 1, 8'h80, 0, 0};
      vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 8'h01, 0, 0};
      vecs[5] = '{8'hA5, 1'b0, 1'b0, 0, 8'h01, 1, 0};
      vecs[6] = '{8'h5A, 1'b1, 1'b0, 1, 8'h5A, 0, 0};
      vecs[7] = '{8'h07, 1'b1, 1'b0, 1, 8'h07, 0, 0};
      vecs[8] = '{8'h07, 1'b1, 1'b1, 1, 8'h07, 0, PAR_EN};

      // Reset state.
      rst = 1'b1;
      rxd = 1'b1;
      tick(3);
      check("reset rx_data", int'(rx_data), 0);
      check("reset rx_data_fresh", int'(rx_data_fresh), 0);
      check("reset framing_err", int'(framing_err), 0);
      check("reset glitch_err", int'(glitch_err), 0);
      check("reset parity_err", int'(parity_err), 0);
      check("reset rx_busy", int'(rx_busy), 0);
      rst = 1'b0;
      tick(4);

      // Table of single frames.
      for (int v = 0; v < NV; v++) begin
         f0 = n_fresh; fe0 = n_ferr; g0 = n_gerr; p0 = n_perr;
         send_frame(vecs[v].data, vecs[v].stop_b, vecs[v].flip, sc);
         rxd = 1'b1;
         tick(2 * CPB);
         check($sformatf("vec%0d fresh count", v), n_fresh - f0, vecs[v].exp_fresh);
         check($sformatf("vec%0d rx_data", v), int'(rx_data), int'(vecs[v].exp_data));
         check($sformatf("vec%0d framing_err count", v), n_ferr - fe0, vecs[v].exp_ferr);
         check($sformatf("vec%0d glitch_err count", v), n_gerr - g0, 0);
         check($sformatf("vec%0d parity_err count", v), n_perr - p0, vecs[v].exp_perr);
         if (vecs[v].exp_fresh == 1 && n_fresh - f0 == 1) begin
            lat = fresh_cyc - sc;
            n_tests++;
            if (lat < LAT - 1 || lat > LAT + 1) begin
               n_fail++;
               $display("FAIL vec%0d latency: got %0d clocks, expected %0d +/-1", v, lat, LAT);
            end
         end
         $display("[TB] vec%0d data=0x%02h stop=%0b flip=%0b -> rx_data=0x%02h", v,
                  vecs[v].data, vecs[v].stop_b, vecs[v].flip, rx_data);
      end

      // Back-to-back stream 'a'..'z'.
      f0 = n_fresh; fe0 = n_ferr; qb = fresh_q.size();
      for (int c = 8'h61; c <= 8'h7A; c++) send_frame(8'(c), 1'b1, 1'b0, sc);
      tick(2 * CPB);
      check("stream fresh count", n_fresh - f0, 26);
      check("stream framing_err count", n_ferr - fe0, 0);
      for (int k = 0; k < 26; k++) begin
         got = (qb + k < fresh_q.size()) ? int'(fresh_q[qb + k]) : -1;
         check($sformatf("stream byte %0d", k), got, 8'h61 + k);
      end
      $display("[TB] stream of 26 bytes, %0d strobes", n_fresh - f0);

      // Short low pulse: glitch start.
      f0 = n_fresh; g0 = n_gerr;
      rxd = 1'b0;
      tick(4);
      rxd = 1'b1;
      check("glitch busy after start", int'(rx_busy), 1);
      w = 0;
      while (rx_busy && w < 16) begin
         tick(1);
         w++;
      end
      check("glitch busy released", int'(rx_busy), 0);
      tick(CPB);
      check("glitch_err count", n_gerr - g0, 1);
      check("glitch fresh count", n_fresh - f0, 0);
      $display("[TB] glitch pulse, busy released after %0d clocks", w);

      // Stop bit low, held low, then a good frame.
      f0 = n_fresh; fe0 = n_ferr; g0 = n_gerr;
      send_frame(8'h55, 1'b0, 1'b0, sc);
      tick(48);
      check("break busy", int'(rx_busy), 1);
      rxd = 1'b1;
      tick(CPB);
      send_frame(8'h33, 1'b1, 1'b0, sc);
      tick(2 * CPB);
      check("break framing_err count", n_ferr - fe0, 1);
      check("break fresh count", n_fresh - f0, 1);
      check("break rx_data", int'(rx_data), 8'h33);
      check("break glitch_err count", n_gerr - g0, 0);
      $display("[TB] break then 0x33 -> rx_data=0x%02h", rx_data);

      // Reset in the data bits of 0xA5; the transmitter abandons that frame.
      f0 = n_fresh; fe0 = n_ferr; g0 = n_gerr;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rxd = 1'b1;
      tick(H);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midframe reset rx_data", int'(rx_data), 0);
      check("midframe reset rx_busy", int'(rx_busy), 0);
      tick(2 * CPB);
      send_frame(8'h3C, 1'b1, 1'b0, sc);
      tick(2 * CPB);
      check("after reset fresh count", n_fresh - f0, 1);
      check("after reset rx_data", int'(rx_data), 8'h3C);
      check("after reset error count", (n_ferr - fe0) + (n_gerr - g0), 0);
      $display("[TB] reset mid 0xA5 then 0x3C -> rx_data=0x%02h", rx_data);

      check("exclusive strobes", n_excl, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
